logcmp_issue: RTL and testbench
===============================

Name: logcmp_issue

Overview:
- Issue queue and scheduler for the single-cycle logic/compare execution unit (slt/sltu, xor, or, and).
- Accepts renamed micro-ops from dispatch and holds them until both source physical registers are marked written back.
- Selects the oldest ready entry, reads its operands from the physical register file, and presents a registered execute_vaild/execute_info pair to the execute unit one cycle later.

Parameters:
- DP, 4, queue depth in entries (2..8).
- RNBIT, 2, rename bits per architectural register; physical register index width is PW = 5+RNBIT.

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; discard all queued and in-flight ops
- dispatch_vaild  in  1  dispatch offers one op
- dispatch_ready  out  1  queue can accept (count < DP)
- dispatch_info  in  4+3*PW+1  {fun_slt, fun_xor, fun_or, fun_and, rd0, rs1, rs2, isUsi}
- wbLog  in  32*2^RNBIT  per-physical-register written-back flags
- rs1_addr  out  PW  regfile read port 1 address (combinational from select)
- rs2_addr  out  PW  regfile read port 2 address
- rs1_data  in  64  regfile read port 1 data (same cycle)
- rs2_data  in  64  regfile read port 2 data (same cycle)
- logCmp_execute_vaild  out  1  registered issue strobe to execute unit
- logCmp_execute_info  out  4+PW+129  {fun_slt, fun_xor, fun_or, fun_and, rd0, op1, op2, isUsi}

Behaviour:
- Reset (RSTn low, asynchronous):
  - all entry valid bits = 0, count = 0
  - logCmp_execute_vaild = 0, logCmp_execute_info = 0
  - dispatch_ready = 1 once released
- Storage: compacting queue. Entry 0 is the oldest. Each entry holds a valid bit plus the dispatch_info fields.
- Enqueue:
  - Enqueue occurs when dispatch_vaild && dispatch_ready.
  - The op is written at index (count − issued_this_cycle), after compaction.
  - dispatch_ready = (count < DP). It does not credit a same-cycle issue, so a full queue refuses dispatch even when an issue is happening that cycle.
- Ready test: an entry is ready when valid && wbLog[rs1] && wbLog[rs2]. There is no same-cycle writeback bypass; wbLog is sampled as-is.
- Select:
  - The lowest-index ready entry wins (oldest-first).
  - rs1_addr/rs2_addr = winner's rs1/rs2; when there is no winner, drive entry 0's fields (don't-care).
- Issue, on the edge after select:
  - logCmp_execute_vaild <= 1.
  - logCmp_execute_info <= {winner fun bits, rd0, rs1_data, rs2_data, isUsi}.
  - Entries above the winner shift down by one; count decrements.
  - With no winner, logCmp_execute_vaild <= 0 and info holds its previous value.
- Latency: an op whose operands are already ready, enqueued at edge N, is selectable in cycle N and appears at execute at edge N+1. The execute unit has no backpressure, so at most one issue per cycle.
- Simultaneous enqueue + issue: count is unchanged, and the new op lands at index count−1 after the shift.
- Fun bits must be one-hot. The block does not check this; it passes the bits through unchanged.
- Flush, synchronous and priority over everything:
  - all valid bits = 0, count = 0, logCmp_execute_vaild <= 0 at the next edge
  - an enqueue in the flush cycle is dropped
- Reset mid-operation: immediate clear per the reset values above; no partial state survives.

Optional Feature:
- Macro: LOGCMP_ISSUE_PERF_EN.
- Defined: adds outputs perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_issue_cnt increments on each issue.
  - perf_stall_cnt increments each cycle count > 0 with no ready entry.
  - Both reset to 0 on RSTn, saturate at 32'hFFFF_FFFF, and are not cleared by flush.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Ready op, no wait: wbLog all 1, dispatch xor rs1=3, rs2=5, rd0=9; regfile[3]=64'hF0F0, [5]=64'h0FF0 -> execute_vaild=1 one edge later, info op1=F0F0, op2=0FF0, rd0=9, fun_xor=1.
- Oldest-first: enqueue A (rs1=7 not ready), B (ready), C (ready) -> B issues, then C. Set wbLog[7]=1 -> A issues next; three consecutive issue cycles total, order B, C, A.
- Full: DP=4, four non-ready ops -> dispatch_ready=0. A fifth dispatch_vaild is held off. Make entry 2 ready -> it issues, dispatch_ready=1 the next cycle, and the fifth op lands at index 3.
- Simultaneous: count=2 with entry 0 ready, dispatch in the same cycle -> count stays 2, the new op is at index 1, and the old entry 1 is now at index 0.
- Flush: three queued ops plus an in-flight issue; assert flush together with dispatch_vaild -> next edge count=0 and execute_vaild=0, the dispatched op is dropped, and no further issues occur.
- Async reset: drop RSTn mid-cycle with count=3 -> valid bits and execute_vaild go to 0 immediately without a clock edge. With LOGCMP_ISSUE_PERF_EN defined, both perf counters also read 0.

Source files
------------

// File: rtl/logcmp_issue_if.sv
// logcmp_issue_if: dispatch, regfile-read and execute-issue signals of the logic/compare issue queue.
// Rev 1.0
`default_nettype none

interface logcmp_issue_if #(
   parameter int RNBIT = 2
);
   localparam int PW = 5 + RNBIT;
   localparam int IW = 4 + 3 * PW + 1;
   localparam int EW = 4 + PW + 129;

   logic                       flush;
   logic                       dispatch_vaild;
   logic                       dispatch_ready;
   logic [IW-1:0]              dispatch_info;
   logic [32*(2**RNBIT)-1:0]   wbLog;
   logic [PW-1:0]              rs1_addr;
   logic [PW-1:0]              rs2_addr;
   logic [63:0]                rs1_data;
   logic [63:0]                rs2_data;
   logic                       logCmp_execute_vaild;
   logic [EW-1:0]              logCmp_execute_info;

   modport master (
      output flush, dispatch_vaild, dispatch_info, wbLog, rs1_data, rs2_data,
      input  dispatch_ready, rs1_addr, rs2_addr, logCmp_execute_vaild, logCmp_execute_info
   );

   modport slave (
      input  flush, dispatch_vaild, dispatch_info, wbLog, rs1_data, rs2_data,
      output dispatch_ready, rs1_addr, rs2_addr, logCmp_execute_vaild, logCmp_execute_info
   );
endinterface

`default_nettype wire

// File: rtl/logcmp_issue.sv
// logcmp_issue: compacting oldest-first issue queue for the logic/compare unit. Rev 1.0
// Optional perf counters perf_issue_cnt/perf_stall_cnt: define LOGCMP_ISSUE_PERF_EN.
`default_nettype none

module logcmp_issue #(
   parameter int DP    = 4,
   parameter int RNBIT = 2
) (
   input  logic         CLK,
   input  logic         RSTn,
   logcmp_issue_if.slave bus
`ifdef LOGCMP_ISSUE_PERF_EN
   ,
   output logic [31:0]  perf_issue_cnt,
   output logic [31:0]  perf_stall_cnt
`endif
);
   localparam int PW     = 5 + RNBIT;
   localparam int IW     = 4 + 3 * PW + 1;
   localparam int EW     = 4 + PW + 129;
   localparam int CW     = $clog2(DP + 1);
   localparam int XW     = $clog2(DP);
   localparam int RS2_LO = 1;
   localparam int RS1_LO = PW + 1;
   localparam int RD_LO  = 2 * PW + 1;
   localparam int FUN_LO = 3 * PW + 1;

   logic [DP-1:0] ent_valid;
   logic [DP-1:0] nxt_valid;
   logic [DP-1:0] ready;
   logic [IW-1:0] ent_info [DP];
   logic [IW-1:0] nxt_info [DP];
   logic [CW-1:0] count;
   logic [CW-1:0] nxt_count;
   logic [CW-1:0] enq_idx;
   logic          sel_found;
   logic [XW-1:0] sel_idx;
   logic [IW-1:0] win;
   logic          enq;
   logic          exec_vaild;
   logic [EW-1:0] exec_info;

   // wbLog is used as sampled; a writeback in this cycle is visible next cycle.
   always_comb begin
      ready = '0;
      for (int i = 0; i < DP; i++) begin
         ready[i] = ent_valid[i]
                  & bus.wbLog[ent_info[i][RS1_LO +: PW]]
                  & bus.wbLog[ent_info[i][RS2_LO +: PW]];
      end
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DP - 1; i >= 0; i--) begin
         if (ready[i]) begin
            sel_found = 1'b1;
            sel_idx   = XW'(i);
         end
      end
   end

   assign win                = ent_info[sel_idx];
   assign bus.rs1_addr       = win[RS1_LO +: PW];
   assign bus.rs2_addr       = win[RS2_LO +: PW];
   assign bus.dispatch_ready = (count < CW'(DP));
   assign enq                = bus.dispatch_vaild & bus.dispatch_ready;
   assign enq_idx            = count - CW'(sel_found);

   // Shift out the winner first, then append the new op at the compacted tail.
   always_comb begin
      nxt_valid = ent_valid;
      nxt_info  = ent_info;
      nxt_count = count;
      if (sel_found) begin
         for (int i = 0; i < DP; i++) begin
            if (i >= int'(sel_idx)) begin
               if (i < DP - 1) begin
                  nxt_valid[i] = ent_valid[(i < DP - 1) ? i + 1 : i];
                  nxt_info[i]  = ent_info[(i < DP - 1) ? i + 1 : i];
               end else begin
                  nxt_valid[i] = 1'b0;
               end
            end
         end
         nxt_count = count - CW'(1);
      end
      if (enq) begin
         for (int i = 0; i < DP; i++) begin
            if (CW'(i) == enq_idx) begin
               nxt_valid[i] = 1'b1;
               nxt_info[i]  = bus.dispatch_info;
            end
         end
         nxt_count = nxt_count + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ent_valid  <= '0;
         count      <= '0;
         exec_vaild <= 1'b0;
         exec_info  <= '0;
         for (int i = 0; i < DP; i++) begin
            ent_info[i] <= '0;
         end
      end else if (bus.flush) begin
         ent_valid  <= '0;
         count      <= '0;
         exec_vaild <= 1'b0;
      end else begin
         ent_valid  <= nxt_valid;
         ent_info   <= nxt_info;
         count      <= nxt_count;
         exec_vaild <= sel_found;
         if (sel_found) begin
            exec_info <= {win[FUN_LO +: 4], win[RD_LO +: PW],
                          bus.rs1_data, bus.rs2_data, win[0]};
         end
      end
   end

   assign bus.logCmp_execute_vaild = exec_vaild;
   assign bus.logCmp_execute_info  = exec_info;

`ifdef LOGCMP_ISSUE_PERF_EN
   // Counters survive flush; only RSTn clears them.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (sel_found && !bus.flush && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if ((count != '0) && !sel_found && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_logcmp_issue.sv
// tb_logcmp_issue: directed test-plan steps plus random traffic against a queue-based reference model.
`default_nettype none

module tb_logcmp_issue;
   localparam int DP    = 4;
   localparam int RNBIT = 2;
   localparam int PW    = 5 + RNBIT;
   localparam int IW    = 4 + 3 * PW + 1;
   localparam int EW    = 4 + PW + 129;
   localparam int NREG  = 32 * (2 ** RNBIT);

   logic CLK;
   logic RSTn;
   logcmp_issue_if #(.RNBIT(RNBIT)) bus ();
`ifdef LOGCMP_ISSUE_PERF_EN
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   logcmp_issue #(.DP(DP), .RNBIT(RNBIT)) dut (
      .CLK            (CLK),
      .RSTn           (RSTn),
`ifdef LOGCMP_ISSUE_PERF_EN
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .bus            (bus.slave)
   );

   logic [NREG-1:0] wb;
   logic [63:0]     rf [NREG];
   logic [IW-1:0]   q [$];
   logic [EW-1:0]   exp_info;
   logic [31:0]     issue_m;
   logic [31:0]     stall_m;
   logic [PW-1:0]   last_rd;
   int              chk;
   int              fails;

   assign bus.wbLog    = wb;
   assign bus.rs1_data = rf[bus.rs1_addr];
   assign bus.rs2_data = rf[bus.rs2_addr];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      chk++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] mk(input logic [3:0] f, input logic [PW-1:0] rd,
                                        input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                                        input logic u);
      return {f, rd, s1, s2, u};
   endfunction

   function automatic logic is_rdy(input logic [IW-1:0] e);
      return wb[e[PW+1 +: PW]] && wb[e[1 +: PW]];
   endfunction

   // One clock: drive, check combinational outputs, advance model, check registered outputs.
   task automatic cycle(input logic dv, input logic [IW-1:0] di, input logic fl);
      int   w;
      int   n;
      logic ev;
      logic [IW-1:0] e;
      bus.dispatch_vaild = dv;
      bus.dispatch_info  = di;
      bus.flush          = fl;
      #1;
      check("dispatch_ready", 256'(bus.dispatch_ready), 256'(q.size() < DP));
      w = -1;
      for (int i = 0; i < q.size(); i++) begin
         if (w < 0 && is_rdy(q[i])) w = i;
      end
      if (w >= 0) begin
         e = q[w];
         check("rs1_addr", 256'(bus.rs1_addr), 256'(e[PW+1 +: PW]));
         check("rs2_addr", 256'(bus.rs2_addr), 256'(e[1 +: PW]));
      end
      if (q.size() > 0 && w < 0 && stall_m != 32'hFFFF_FFFF) stall_m++;
      ev = !fl && (w >= 0);
      if (ev) begin
         exp_info = {e[IW-1 -: 4], e[2*PW+1 +: PW], rf[e[PW+1 +: PW]], rf[e[1 +: PW]], e[0]};
         if (issue_m != 32'hFFFF_FFFF) issue_m++;
      end
      n = q.size();
      if (fl) begin
         q.delete();
      end else begin
         if (w >= 0) q.delete(w);
         if (dv && n < DP) q.push_back(di);
      end
      @(posedge CLK);
      #1;
      check("execute_vaild", 256'(bus.logCmp_execute_vaild), 256'(ev));
      check("execute_info", 256'(bus.logCmp_execute_info), 256'(exp_info));
      last_rd = bus.logCmp_execute_info[129 +: PW];
`ifdef LOGCMP_ISSUE_PERF_EN
      check("perf_issue_cnt", 256'(perf_issue_cnt), 256'(issue_m));
      check("perf_stall_cnt", 256'(perf_stall_cnt), 256'(stall_m));
`endif
   endtask

   initial begin
      logic [IW-1:0] op5;
      chk = 0; fails = 0;
      issue_m = '0; stall_m = '0; exp_info = '0; last_rd = '0;
      RSTn = 1'b0;
      bus.flush = 1'b0; bus.dispatch_vaild = 1'b0; bus.dispatch_info = '0;
      wb = '1;
      for (int i = 0; i < NREG; i++) rf[i] = {$urandom, $urandom};
      rf[3] = 64'hF0F0;
      rf[5] = 64'h0FF0;
      repeat (2) @(posedge CLK);
      #1 RSTn = 1'b1;
      #1;
      check("reset_vaild", 256'(bus.logCmp_execute_vaild), 256'(0));
      check("reset_info", 256'(bus.logCmp_execute_info), 256'(0));
      check("reset_ready", 256'(bus.dispatch_ready), 256'(1));

      // Ready op, no wait
      cycle(1'b1, mk(4'b0100, 7'd9, 7'd3, 7'd5, 1'b0), 1'b0);
      cycle(1'b0, '0, 1'b0);
      check("t1_vaild", 256'(bus.logCmp_execute_vaild), 256'(1));
      check("t1_op1", 256'(bus.logCmp_execute_info[65 +: 64]), 256'(64'hF0F0));
      check("t1_op2", 256'(bus.logCmp_execute_info[1 +: 64]), 256'(64'h0FF0));
      check("t1_rd0", 256'(last_rd), 256'(9));
      check("t1_fun", 256'(bus.logCmp_execute_info[EW-1 -: 4]), 256'(4'b0100));

      // Oldest-first: A waits on r7, B and C ready
      wb[7] = 1'b0;
      cycle(1'b1, mk(4'b0001, 7'd1, 7'd7, 7'd0, 1'b0), 1'b0);
      cycle(1'b1, mk(4'b0010, 7'd2, 7'd1, 7'd2, 1'b0), 1'b0);
      cycle(1'b1, mk(4'b1000, 7'd3, 7'd4, 7'd6, 1'b1), 1'b0);
      check("t2_first_B", 256'(last_rd), 256'(2));
      cycle(1'b0, '0, 1'b0);
      check("t2_second_C", 256'(last_rd), 256'(3));
      wb[7] = 1'b1;
      cycle(1'b0, '0, 1'b0);
      check("t2_third_A", 256'(last_rd), 256'(1));
      cycle(1'b0, '0, 1'b0);

      // Full queue, entry 2 becomes ready, fifth op lands at the tail
      wb[13:10] = 4'b0000;
      for (int i = 0; i < 4; i++)
         cycle(1'b1, mk(4'b0001, PW'(40 + i), PW'(10 + i), 7'd0, 1'b0), 1'b0);
      op5 = mk(4'b0100, 7'd44, 7'd0, 7'd1, 1'b0);
      cycle(1'b1, op5, 1'b0);
      check("t3_full_ready", 256'(bus.dispatch_ready), 256'(0));
      wb[12] = 1'b1;
      cycle(1'b1, op5, 1'b0);
      check("t3_entry2", 256'(last_rd), 256'(42));
      cycle(1'b1, op5, 1'b0);
      cycle(1'b0, '0, 1'b0);
      check("t3_op5", 256'(last_rd), 256'(44));
      wb = '1;
      cycle(1'b0, '0, 1'b0);
      check("t3_drain0", 256'(last_rd), 256'(40));
      cycle(1'b0, '0, 1'b0);
      check("t3_drain1", 256'(last_rd), 256'(41));
      cycle(1'b0, '0, 1'b0);
      check("t3_drain3", 256'(last_rd), 256'(43));

      // Simultaneous enqueue and issue
      wb[15:14] = 2'b00;
      cycle(1'b1, mk(4'b0010, 7'd20, 7'd15, 7'd0, 1'b0), 1'b0);
      cycle(1'b1, mk(4'b0010, 7'd21, 7'd14, 7'd0, 1'b0), 1'b0);
      wb[15] = 1'b1;
      cycle(1'b1, mk(4'b1000, 7'd22, 7'd2, 7'd3, 1'b1), 1'b0);
      check("t4_X", 256'(last_rd), 256'(20));
      cycle(1'b0, '0, 1'b0);
      check("t4_Z", 256'(last_rd), 256'(22));
      wb[14] = 1'b1;
      cycle(1'b0, '0, 1'b0);
      check("t4_Y", 256'(last_rd), 256'(21));

      // Flush with an op in flight and a dispatch in the same cycle
      wb[18:16] = 3'b000;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, mk(4'b0001, PW'(50 + i), PW'(16 + i), 7'd0, 1'b0), 1'b0);
      cycle(1'b1, mk(4'b0100, 7'd30, 7'd1, 7'd1, 1'b0), 1'b0);
      cycle(1'b0, '0, 1'b0);
      check("t5_inflight", 256'(bus.logCmp_execute_vaild), 256'(1));
      cycle(1'b1, mk(4'b0100, 7'd31, 7'd1, 7'd1, 1'b0), 1'b1);
      wb = '1;
      repeat (3) cycle(1'b0, '0, 1'b0);

      // Asynchronous reset mid-cycle
      wb[18:16] = 3'b000;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, mk(4'b0010, PW'(60 + i), PW'(16 + i), 7'd0, 1'b0), 1'b0);
      cycle(1'b1, mk(4'b0001, 7'd33, 7'd1, 7'd2, 1'b0), 1'b0);
      cycle(1'b0, '0, 1'b0);
      #3 RSTn = 1'b0;
      #1;
      check("rst_async_vaild", 256'(bus.logCmp_execute_vaild), 256'(0));
      check("rst_async_info", 256'(bus.logCmp_execute_info), 256'(0));
      check("rst_async_ready", 256'(bus.dispatch_ready), 256'(1));
`ifdef LOGCMP_ISSUE_PERF_EN
      check("rst_perf_issue", 256'(perf_issue_cnt), 256'(0));
      check("rst_perf_stall", 256'(perf_stall_cnt), 256'(0));
`endif
      q.delete();
      exp_info = '0; issue_m = '0; stall_m = '0;
      #1 RSTn = 1'b1;
      wb = '1;
      repeat (2) cycle(1'b0, '0, 1'b0);

      // Random traffic against the model
      for (int t = 0; t < 400; t++) begin
         for (int j = 0; j < NREG / 32; j++) wb[j*32 +: 32] = $urandom | $urandom;
         cycle($urandom_range(0, 2) != 0,
               mk(4'b0001 << $urandom_range(0, 3), PW'($urandom), PW'($urandom),
                  PW'($urandom), 1'($urandom)),
               $urandom_range(0, 30) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
      $finish;
   end
endmodule

`default_nettype wire
